// File: rtl/sysmgr_pkg.sv
// Shared definitions for the system-manager reset sequencer: FSM encoding,
// loss-counter width and a saturating increment helper.
package sysmgr_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_SOFT      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    logic [LOSS_CNT_W-1:0] res;
    if (v == {LOSS_CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + LOSS_CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/sysmgr_lock_filt.sv
// PLL lock qualifier: 2-FF synchroniser followed by a consecutive-sample filter.
// lock_ok rises after LOCK_FILT high samples and drops one cycle after any low sample.
module sysmgr_lock_filt #(
  parameter int LOCK_FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILT + 1);

  logic [1:0]    r_sync;
  logic [FW-1:0] r_cnt;
  logic          r_lock_ok;

  // synchroniser and run-length filter; r_cnt saturates at LOCK_FILT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_cnt     <= '0;
      r_lock_ok <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], pll_lock};
      if (r_sync[1]) begin
        if (r_cnt != FW'(LOCK_FILT)) begin
          r_cnt <= r_cnt + FW'(1);
        end else begin
          r_cnt <= r_cnt;
        end
        r_lock_ok <= (r_cnt >= FW'(LOCK_FILT - 1));
      end else begin
        r_cnt     <= '0;
        r_lock_ok <= 1'b0;
      end
    end
  end

  assign lock_ok = r_lock_ok;

endmodule

// File: rtl/sysmgr_rst_seq.sv
// Reset sequencer: waits for filtered PLL lock, holds all resets, then releases
// channels one by one; soft requests re-run the release for a masked subset.
module sysmgr_rst_seq
  import sysmgr_pkg::*;
#(
  parameter int              N_CH      = 2,
  parameter int              HOLD_CYC  = 8,
  parameter int              STAGGER   = 4,
  parameter int              LOCK_FILT = 3,
  parameter logic [N_CH-1:0] SOFT_MASK = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  soft_req,
  output logic [N_CH-1:0]       rst_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int REL_SPAN = (N_CH - 1) * STAGGER + 1;
  localparam int CNT_MAX  = (HOLD_CYC > REL_SPAN) ? HOLD_CYC : REL_SPAN;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W    = $clog2(N_CH + 1);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [N_CH-1:0]       r_rst_out;
  logic                  r_ready;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  w_lock_ok;

  sysmgr_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_lock_filt (
    .clk     (clk),
    .rst     (rst),
    .pll_lock(pll_lock),
    .lock_ok (w_lock_ok)
  );

  // sequencing FSM; r_cnt is shared between hold time and release stagger
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else if ((r_state != ST_WAIT_LOCK) && !w_lock_ok) begin
      // lock loss outranks everything, including a coincident soft request
      r_state    <= ST_WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_ready    <= 1'b0;
      r_loss_cnt <= sat_inc(r_loss_cnt);
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          r_rst_out <= '1;
          r_ready   <= 1'b0;
          if (w_lock_ok) begin
            r_state <= ST_HOLD;
            r_cnt   <= CNT_W'(HOLD_CYC - 1);
          end else begin
            r_state <= ST_WAIT_LOCK;
          end
        end
        ST_HOLD, ST_SOFT: begin
          if (r_cnt == '0) begin
            r_state      <= ST_RELEASE;
            r_rst_out[0] <= 1'b0;
            r_idx        <= IDX_W'(1);
            r_cnt        <= (N_CH == 1) ? '0 : CNT_W'(STAGGER - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_idx == IDX_W'(N_CH)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            for (int k = 0; k < N_CH; k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_rst_out[k] <= 1'b0;
              end
            end
            r_idx <= r_idx + IDX_W'(1);
            // after the last channel wait exactly one cycle before RUN
            r_cnt <= (r_idx == IDX_W'(N_CH - 1)) ? '0 : CNT_W'(STAGGER - 1);
          end
        end
        ST_RUN: begin
          if (soft_req) begin
            r_state   <= ST_SOFT;
            r_rst_out <= r_rst_out | SOFT_MASK;
            r_ready   <= 1'b0;
            r_cnt     <= CNT_W'(HOLD_CYC - 1);
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state   <= ST_WAIT_LOCK;
          r_rst_out <= '1;
          r_ready   <= 1'b0;
          r_cnt     <= '0;
          r_idx     <= '0;
        end
      endcase
    end
  end

  assign rst_out       = r_rst_out;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Directed bench for sysmgr_rst_seq. "cycle N" is the interval ending at the edge
// that samples inputs set for cycle N; outputs are checked 1 time unit after edge N-1.
module tb_sysmgr_rst_seq;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       soft_req;
  logic [1:0] rst_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int cyc;
  int n_checks;
  int n_errors;

  sysmgr_rst_seq dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .soft_req     (soft_req),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_out(input string tag, input logic [1:0] exp_rst, input logic exp_rdy);
    check_val({tag, "_rst_out"}, 32'(rst_out), 32'(exp_rst));
    check_val({tag, "_ready"}, 32'(ready), 32'(exp_rdy));
  endtask

  // release timeline with ch0 dropping at cycle t
  task automatic check_seq(input string tag, input int t);
    wait_to(t - 1); chk_out({tag, "_hold"}, 2'b11, 1'b0);
    wait_to(t);     chk_out({tag, "_ch0"},  2'b10, 1'b0);
    wait_to(t + 3); chk_out({tag, "_gap"},  2'b10, 1'b0);
    wait_to(t + 4); chk_out({tag, "_ch1"},  2'b00, 1'b0);
    wait_to(t + 5); chk_out({tag, "_run"},  2'b00, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    pll_lock = 1'b0;
    soft_req = 1'b0;

    // reset and power-up sequence
    repeat (4) step();
    chk_out("reset", 2'b11, 1'b0);
    check_val("reset_cnt", 32'(lock_loss_cnt), 32'd0);
    cyc = 0; rst = 1'b0; pll_lock = 1'b1;
    check_seq("pwrup", 14);

    // one-cycle lock glitch during HOLD
    rst = 1'b1; pll_lock = 1'b0;
    repeat (4) step();
    cyc = 0; rst = 1'b0; pll_lock = 1'b1;
    wait_to(8);  pll_lock = 1'b0;
    wait_to(9);  pll_lock = 1'b1;
    wait_to(11); check_val("glitch_cnt0", 32'(lock_loss_cnt), 32'd0);
    chk_out("glitch_pre", 2'b11, 1'b0);
    wait_to(12); check_val("glitch_cnt1", 32'(lock_loss_cnt), 32'd1);
    chk_out("glitch_wait", 2'b11, 1'b0);
    check_seq("reseq", 23);

    // soft reset from RUN
    cyc = 0; soft_req = 1'b1;
    step(); soft_req = 1'b0;
    chk_out("soft_c1", 2'b10, 1'b0);
    for (int c = 2; c <= 14; c++) begin
      wait_to(c);
      chk_out("soft", (c < 13) ? 2'b10 : 2'b00, (c >= 14));
    end

    // lock loss in RUN with a coincident soft request
    cyc = 0; pll_lock = 1'b0;
    wait_to(3); chk_out("loss_pre", 2'b00, 1'b1); soft_req = 1'b1;
    wait_to(4); soft_req = 1'b0;
    chk_out("loss", 2'b11, 1'b0);
    check_val("loss_cnt", 32'(lock_loss_cnt), 32'd2);
    wait_to(6); chk_out("loss_nosoft", 2'b11, 1'b0);

    // relock with soft requests in HOLD and RELEASE, both ignored
    cyc = 0; pll_lock = 1'b1;
    wait_to(8);  soft_req = 1'b1;
    wait_to(9);  soft_req = 1'b0;
    wait_to(13); chk_out("ign_hold", 2'b11, 1'b0);
    wait_to(14); chk_out("ign_ch0", 2'b10, 1'b0);
    wait_to(15); soft_req = 1'b1;
    wait_to(16); soft_req = 1'b0;
    wait_to(17); chk_out("ign_gap", 2'b10, 1'b0);
    wait_to(18); chk_out("ign_ch1", 2'b00, 1'b0);
    wait_to(19); chk_out("ign_run", 2'b00, 1'b1);
    check_val("ign_cnt", 32'(lock_loss_cnt), 32'd2);

    // synchronous reset in the middle of a release
    cyc = 0; soft_req = 1'b1;
    step(); soft_req = 1'b0;
    wait_to(10); chk_out("mid_rel", 2'b10, 1'b0); rst = 1'b1;
    wait_to(11); rst = 1'b0;
    chk_out("mid_rst", 2'b11, 1'b0);
    check_val("mid_rst_cnt", 32'(lock_loss_cnt), 32'd0);
    cyc = 0;
    check_seq("after_rst", 14);

    // 300 lock losses: counter saturates
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (5) step();
      if (i == 2)   check_val("sat_3", 32'(lock_loss_cnt), 32'd3);
      if (i == 253) check_val("sat_254", 32'(lock_loss_cnt), 32'd254);
      if (i == 254) check_val("sat_255", 32'(lock_loss_cnt), 32'd255);
      pll_lock = 1'b1;
      repeat (10) step();
    end
    check_val("sat_final", 32'(lock_loss_cnt), 32'd255);
    chk_out("sat_hold", 2'b11, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
